// File: rtl/pipe_ctrl_pkg.sv
// Shared types and limits for the pipeline stall/flush sequencer.
// The multiply FSM counts EX occupancy in a CNT_W-bit counter.
package pipe_ctrl_pkg;

  localparam int CNT_W       = 4;
  localparam int MUL_LAT_MAX = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load in EX.
// Purely combinational; x0 never creates a hazard.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer merging bus waits, multiply occupancy, load-use bubbles and EX redirects.
// Outputs are combinational (zero latency); HAZ_PERF_EN adds stall/bubble/flush event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       axi_im_busy_i,
  input  logic       axi_dm_busy_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_mul_i,
  input  logic       ex_redirect_i,
  output logic       stall_axi_im_o,
  output logic       stall_axi_dm_o,
  output logic       stall_o,
  output logic       id_flush_o,
  output logic       ex_flush_o,
  output logic       mul_busy_o
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MUL_LAT - 1);
  localparam bit               MUL_MULTI = (MUL_LAT > 1);

  mul_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             flush_pend;
  logic             mul_freeze;
  logic             bus_freeze;
  logic             freeze;
  logic             flush_req;
  logic             flush;
  logic             hazard;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .id_use_rs1  (id_use_rs1_i),
    .id_use_rs2  (id_use_rs2_i),
    .ex_rd       (ex_rd_i),
    .ex_mem_read (ex_mem_read_i),
    .hazard      (hazard)
  );

  assign bus_freeze = axi_im_busy_i || axi_dm_busy_i;

  // MUL_DONE parks a finished multiply until the bus releases, so it cannot retrigger.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mul_freeze = 1'b0;
    case (state)
      RUN: begin
        if (ex_mul_i && MUL_MULTI) begin
          mul_freeze = 1'b1;
          cnt_nx     = CNT_W'(1);
          state_nx   = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (cnt != CNT_LAST) begin
          mul_freeze = 1'b1;
          cnt_nx     = cnt + 1'b1;
        end else begin
          state_nx = bus_freeze ? MUL_DONE : RUN;
        end
      end
      MUL_DONE: begin
        if (!bus_freeze) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign freeze    = bus_freeze || mul_freeze;
  assign flush_req = ex_redirect_i || flush_pend;
  assign flush     = !rst_i && !freeze && flush_req;

  assign stall_axi_im_o = !rst_i && (axi_im_busy_i || mul_freeze);
  assign stall_axi_dm_o = !rst_i && axi_dm_busy_i;
  assign id_flush_o     = flush;
  assign ex_flush_o     = flush;
  assign stall_o        = !rst_i && !freeze && !flush_req && hazard;
  assign mul_busy_o     = !rst_i && (state != RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (freeze) begin
        if (ex_redirect_i) flush_pend <= 1'b1;
      end else begin
        flush_pend <= 1'b0;
      end
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      bubble_cnt_o   <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (freeze)  stall_cycles_o <= stall_cycles_o + 32'd1;
      if (stall_o) bubble_cnt_o   <= bubble_cnt_o + 32'd1;
      if (flush)   flush_cnt_o    <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MUL_LAT=3): stimulus pushes expected outputs, a monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       im_busy, dm_busy;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mem_read, mul, redir;
  logic       stall_im, stall_dm, stall, id_flush, ex_flush, mul_busy;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles, bubble_cnt, flush_cnt;
`endif

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   pushed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .axi_im_busy_i  (im_busy),
    .axi_dm_busy_i  (dm_busy),
    .id_rs1_i       (rs1),
    .id_rs2_i       (rs2),
    .id_use_rs1_i   (use1),
    .id_use_rs2_i   (use2),
    .ex_rd_i        (rd),
    .ex_mem_read_i  (mem_read),
    .ex_mul_i       (mul),
    .ex_redirect_i  (redir),
    .stall_axi_im_o (stall_im),
    .stall_axi_dm_o (stall_dm),
    .stall_o        (stall),
    .id_flush_o     (id_flush),
    .ex_flush_o     (ex_flush),
    .mul_busy_o     (mul_busy)
`ifdef HAZ_PERF_EN
    ,
    .stall_cycles_o (stall_cycles),
    .bubble_cnt_o   (bubble_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  // Expected word order: {stall_axi_im, stall_axi_dm, stall, id_flush, ex_flush, mul_busy}
  task automatic drive(input logic r, input logic im, input logic dm,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic mr, input logic ml, input logic rdr,
                       input logic [5:0] exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; im_busy = im; dm_busy = dm;
    rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
    rd = d; mem_read = mr; mul = ml; redir = rdr;
    e.exp  = exp;
    e.name = nm;
    q.push_back(e);
    pushed++;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {stall_im, stall_dm, stall, id_flush, ex_flush, mul_busy};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; im_busy = 1'b0; dm_busy = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    use1 = 1'b0; use2 = 1'b0; mem_read = 1'b0; mul = 1'b0; redir = 1'b0;

    //     rst im dm rs1   u1 rs2   u2 rd    mr mul rdr  expected
    drive(1, 1, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 6'b000000, "reset_outputs_zero");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "idle_after_reset");
    // load-use
    drive(0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 6'b001000, "loaduse_rs1_bubble");
    drive(0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "loaduse_next_cycle");
    drive(0, 0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000, "loaduse_rd_x0");
    drive(0, 0, 0, 5'd1, 1, 5'd9, 0, 5'd9, 1, 0, 0, 6'b000000, "loaduse_rs2_unused");
    drive(0, 0, 0, 5'd1, 1, 5'd9, 1, 5'd9, 1, 0, 0, 6'b001000, "loaduse_rs2_bubble");
    // multiply, no bus wait
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b100000, "mul_start_freeze");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b100001, "mul_wait_freeze");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000001, "mul_last_release");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "mul_back_to_run");
    // multiply with DM wait for 5 cycles
    drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b110000, "muldm_start");
    drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b110001, "muldm_wait");
    drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b010001, "muldm_last_to_done");
    drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b010001, "muldm_done_hold1");
    drive(0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b010001, "muldm_done_hold2");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000001, "muldm_busy_drops");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "muldm_run");
    // redirect while IM busy
    drive(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 6'b100000, "redir_frozen_pulse");
    drive(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b100000, "redir_frozen_2");
    drive(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b100000, "redir_frozen_3");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000110, "redir_replay");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "redir_replay_once");
    // redirect beats load-use
    drive(0, 0, 0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 1, 6'b000110, "redir_over_hazard");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "idle_2");
    // reset mid multiply with a pending flush
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b100000, "rstmul_start");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 6'b100001, "rstmul_redir_latched");
    drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000000, "rstmul_in_reset");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "rstmul_cleared");
    // freeze masks load-use
    drive(0, 0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 6'b010000, "freeze_masks_hazard");
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, "idle_3");

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0 || total - 1 != pushed) begin
      bad++;
      $display("FAIL drain: checked %0d expected %0d", total - 1, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
